// File: rtl/vga_pkg.sv
`default_nettype none
// =====================================================================
// vga_pkg : default 640x480@60 timing, totals helper, flag bundle
// Rev 1.0
// =====================================================================
package vga_pkg;

  localparam int c_H_ACTIVE = 640;
  localparam int c_H_FP     = 16;
  localparam int c_H_SYNC   = 96;
  localparam int c_H_BP     = 48;
  localparam int c_V_ACTIVE = 480;
  localparam int c_V_FP     = 10;
  localparam int c_V_SYNC   = 2;
  localparam int c_V_BP     = 33;

  // Standard 640x480@60 drives both syncs low while asserted.
  localparam logic c_SYNC_ACTIVE_LOW = 1'b0;

  // Colour latency of the game's bitmap_gen, in pixel ticks.
  localparam int c_BITMAP_GEN_LAT = 1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } vga_flags_t;

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// =====================================================================
// vga_delay_line : DEPTH-stage enabled shift register, sync clear
// Rev 1.0
// =====================================================================
module vga_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, i_en, i_clr};
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else if (i_clr) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else if (i_en) begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_video_out.sv
`default_nettype none
// =====================================================================
// vga_video_out : VGA timing, latency-aligned sync/blank and RGB pins
// Rev 1.0
// =====================================================================
module vga_video_out
  import vga_pkg::*;
#(
  parameter int   RGB_W    = 8,
  parameter int   H_ACTIVE = c_H_ACTIVE,
  parameter int   H_FP     = c_H_FP,
  parameter int   H_SYNC   = c_H_SYNC,
  parameter int   H_BP     = c_H_BP,
  parameter int   V_ACTIVE = c_V_ACTIVE,
  parameter int   V_FP     = c_V_FP,
  parameter int   V_SYNC   = c_V_SYNC,
  parameter int   V_BP     = c_V_BP,
  parameter int   TICK_DIV = 2,
  parameter int   PIPE_LAT = c_BITMAP_GEN_LAT,
  parameter logic SYNC_POL = c_SYNC_ACTIVE_LOW,
  parameter int   X_W      = 10,
  parameter int   Y_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             p_tick,
  output logic [X_W-1:0]   pixel_x,
  output logic [Y_W-1:0]   pixel_y,
  output logic             video_on,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb_out
);

  localparam int c_H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int c_V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int c_DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  generate
    if (((2 ** X_W) < c_H_TOTAL) || ((2 ** Y_W) < c_V_TOTAL) ||
        (TICK_DIV < 1) || (PIPE_LAT < 0)) begin : g_param_err
      $error("vga_video_out: illegal geometry, TICK_DIV or PIPE_LAT");
    end
  endgenerate

  // Bounds carry one spare bit so an active region of exactly 2**X_W still compares.
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
  localparam logic [X_W-1:0]     c_H_LAST   = X_W'(c_H_TOTAL - 1);
  localparam logic [Y_W-1:0]     c_V_LAST   = Y_W'(c_V_TOTAL - 1);
  localparam logic [X_W:0]       c_H_ACT    = (X_W+1)'(H_ACTIVE);
  localparam logic [Y_W:0]       c_V_ACT    = (Y_W+1)'(V_ACTIVE);
  localparam logic [X_W:0]       c_HS_FIRST = (X_W+1)'(H_ACTIVE + H_FP);
  localparam logic [X_W:0]       c_HS_LAST  = (X_W+1)'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W:0]       c_VS_FIRST = (Y_W+1)'(V_ACTIVE + V_FP);
  localparam logic [Y_W:0]       c_VS_LAST  = (Y_W+1)'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [c_DIV_W-1:0] r_div;
  logic [X_W-1:0]     r_h;
  logic [Y_W-1:0]     r_v;
  logic               r_hsync;
  logic               r_vsync;
  logic [RGB_W-1:0]   r_rgb;

  logic               w_tick;
  logic               w_h_last;
  logic               w_v_last;
  logic               w_video_on;
  logic               w_hs_raw;
  logic               w_vs_raw;
  vga_flags_t         w_flags_in;
  vga_flags_t         w_flags_tail;

  assign w_tick   = en && (r_div == c_DIV_LAST);
  assign w_h_last = (r_h == c_H_LAST);
  assign w_v_last = (r_v == c_V_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (!en || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!en) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign w_video_on = ({1'b0, r_h} < c_H_ACT) && ({1'b0, r_v} < c_V_ACT);
  assign w_hs_raw   = ({1'b0, r_h} >= c_HS_FIRST) && ({1'b0, r_h} <= c_HS_LAST);
  assign w_vs_raw   = ({1'b0, r_v} >= c_VS_FIRST) && ({1'b0, r_v} <= c_VS_LAST);

  assign w_flags_in = '{hs: w_hs_raw, vs: w_vs_raw, von: w_video_on};

  // Flags travel alongside the generator's pipeline so colour and sync stay paired.
  vga_delay_line #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   ($bits(vga_flags_t)),
    .RST_VAL ('0)
  ) u_flag_pipe (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_tick),
    .i_clr (!en),
    .i_d   (w_flags_in),
    .o_q   (w_flags_tail)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_rgb   <= '0;
    end else if (!en) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_rgb   <= '0;
    end else if (w_tick) begin
      r_hsync <= w_flags_tail.hs ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_flags_tail.vs ? SYNC_POL : ~SYNC_POL;
      r_rgb   <= w_flags_tail.von ? rgb_in : '0;
    end
  end

  assign p_tick      = w_tick;
  assign pixel_x     = r_h;
  assign pixel_y     = r_v;
  assign video_on    = w_video_on;
  assign frame_start = w_tick && w_h_last && w_v_last;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign rgb_out     = r_rgb;

endmodule
`default_nettype wire

// File: doc/vga_video_out.md
# vga_video_out

Parametrised VGA timing and output stage for the game's display path: generates the pixel tick, pixel coordinates and blanking, and accepts colour from a pixel generator with configurable pipeline latency. It also delays sync and blanking to match that latency and drives registered `rgb_out`, `hsync` and `vsync` to the pins. It replaces the fixed 640x480 / 8-bit / one-register arrangement. Geometry, colour width, clock divide, sync polarity and generator latency are all parameters.

## Interface
- `RGB_W`, 8, colour bus width
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48, horizontal timing in pixels
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33, vertical timing in lines
- `TICK_DIV`, 2, clk cycles per pixel (≥1)
- `PIPE_LAT`, 1, p_ticks from coordinates to valid `rgb_in` (≥0)
- `SYNC_POL`, 0, asserted sync level (0 = active-low)
- `X_W`/`Y_W`, 10/10, coordinate widths
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-low
- `en` in 1: run; low = synchronous clear
- `rgb_in` in RGB_W: pixel colour from generator
- `p_tick` out 1: one-clk pixel strobe
- `pixel_x` out X_W: current h counter
- `pixel_y` out Y_W: current v counter
- `video_on` out 1: undelayed active flag for (`pixel_x`, `pixel_y`)
- `frame_start` out 1: one-clk pulse at frame wrap
- `hsync`, `vsync` out 1: registered, latency-aligned
- `rgb_out` out RGB_W: registered, blanked colour

## Operation
- H_TOTAL = sum of H params; V_TOTAL = sum of V params.
- Elaboration error if `2^X_W < H_TOTAL`, `2^Y_W < V_TOTAL`, `TICK_DIV<1` or `PIPE_LAT<0`.
- Divider counts 0..TICK_DIV-1. `p_tick`=1 when the count is TICK_DIV-1. With TICK_DIV=1, `p_tick` is constant 1 while `en`=1.
- On `p_tick`, h increments and wraps at H_TOTAL-1. When h wraps, v increments and wraps at V_TOTAL-1.
- `video_on` = (h < H_ACTIVE) && (v < V_ACTIVE).
- Raw hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Raw vsync asserted likewise on v.
- Delay line: PIPE_LAT stages of {hs, vs, von}, advanced only on `p_tick`. PIPE_LAT=0 means a direct path.
- On `p_tick`, output registers load from the delay line tail:
  - `hsync`/`vsync` = tail flags mapped to SYNC_POL.
  - `rgb_out` = tail von ? `rgb_in` : 0.
- `frame_start` = `p_tick` && h==H_TOTAL-1 && v==V_TOTAL-1.
- `en` low (sampled each clk): clears divider, counters and delay line. Outputs go to reset values. `p_tick`=0. Counting resumes from (0,0) on the first clk with `en`=1.
- Async `reset` low, any time: divider, h, v = 0. Delay stages = inactive. `rgb_out`=0. `hsync`/`vsync` = ~SYNC_POL. `frame_start`=0.

## Timing
- Coordinates and `video_on` change in the clk following a `p_tick`. They are stable for TICK_DIV clks.
- The generator must present colour for the coordinates shown at tick t on `rgb_in` at tick t+PIPE_LAT.
- Pin outputs for pixel (h,v) appear PIPE_LAT+1 p_ticks after the counters show (h,v). `hsync`, `vsync` and `rgb_out` always refer to the same pixel.
- Outputs change only in the clk after a `p_tick`, or on reset/`en` clear.
- Rising `reset` mid-frame: first `p_tick` occurs TICK_DIV clks later. No partial line is emitted beyond the delay-line flush, which holds blank, inactive-sync values.

## Structure
- Package `vga_pkg`: default 640x480@60 timing constants, the total-computation function, and the sync-polarity localparam.
- Sub-module `vga_delay_line`: parameters DEPTH and WIDTH, with enable and async active-low reset to a parameter value. It is instantiated for the {hs, vs, von} pipe.
- Top-level game integration: instantiate with the game's `bitmap_gen` latency as PIPE_LAT.

## Test plan
Small geometry for all scenarios: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), TICK_DIV=2, PIPE_LAT=2, RGB_W=8.
- **Reset:** hold `reset`=0 for 5 clks. Required: `rgb_out`=0, `hsync`=`vsync`=1, `pixel_x`=`pixel_y`=0, `p_tick`=0.
- **Free run:** release and run 2 frames. Required: `p_tick` every 2nd clk; `frame_start` exactly every 256 clks; `hsync` low 3 p_ticks per line, starting at pixel 10+3; `vsync` low for lines 5–6 (+latency).
- **Latency alignment:** drive `rgb_in` = {pixel_y[2:0], pixel_x[4:0]} delayed 2 ticks. Required: `rgb_out` for active pixel (5,2) = 8'h45, 3 p_ticks after the counters show (5,2).
- **Blanking:** `rgb_in` forced to 8'hFF. Required: `rgb_out`=0 for all h≥8 or v≥4; 8'hFF on all 32 active pixels per frame.
- **en clear:** drop `en` mid-line at (6,1) for 3 clks. Required: the next clk shows counters 0, `rgb_out`=0, syncs inactive; counting restarts from (0,0).
- **Async reset mid-frame:** pulse `reset` low for 1 clk at (12,5) with vsync active. Required: immediate return to reset values, with no glitch pulse on `frame_start`.
